// File: rtl/time_digit_pkg.sv
// Shared constants and types for the time <-> digit-stream formatter/parser pair.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Frame layout (acceptance order): HT HU SEP MT MU SEP ST SU SEP DT DU,
// where D is milliseconds / 100. Separator code is SEP_CODE.
package time_digit_pkg;

    localparam logic [3:0] SEP_CODE    = 4'd10;
    localparam int         NUM_SYMBOLS = 11;
    localparam int         IDX_W       = 4;

    localparam logic [IDX_W-1:0] SEP_POS_HM = 4'd2;
    localparam logic [IDX_W-1:0] SEP_POS_MS = 4'd5;
    localparam logic [IDX_W-1:0] SEP_POS_SD = 4'd8;
    localparam logic [IDX_W-1:0] LAST_IDX   = 4'(NUM_SYMBOLS - 1);

    localparam int FIELD_W = 7;
    localparam int MS_W    = 15;

    typedef enum logic {
        COLLECT = 1'b0,
        COMMIT  = 1'b1
    } state_t;

    function automatic logic is_sep_pos(input logic [IDX_W-1:0] idx);
        return (idx == SEP_POS_HM) || (idx == SEP_POS_MS) || (idx == SEP_POS_SD);
    endfunction

    // Maps a digit symbol position onto its staging slot:
    // slots 0..7 = HT HU MT MU ST SU DT DU. Separator positions map to 0
    // but are never written.
    function automatic logic [2:0] digit_slot(input logic [IDX_W-1:0] idx);
        logic [2:0] slot;
        case (idx)
            4'd0:    slot = 3'd0;
            4'd1:    slot = 3'd1;
            4'd3:    slot = 3'd2;
            4'd4:    slot = 3'd3;
            4'd6:    slot = 3'd4;
            4'd7:    slot = 3'd5;
            4'd9:    slot = 3'd6;
            4'd10:   slot = 3'd7;
            default: slot = 3'd0;
        endcase
        return slot;
    endfunction

endpackage

// File: rtl/digit2time_parser_if.sv
// Digit-stream input and parsed-time output bundle for digit2time_parser.
// Latency: n/a (wiring only).
// Backpressure: digit_valid/digit_ready handshake on the digit stream.
//
// master: digit source side (drives clear/digit_in/digit_valid, sees results).
// slave:  parser side.
interface digit2time_parser_if;
    import time_digit_pkg::*;

    logic               clear;
    logic [3:0]         digit_in;
    logic               digit_valid;
    logic               digit_ready;
    logic [FIELD_W-1:0] hs;
    logic [FIELD_W-1:0] min;
    logic [FIELD_W-1:0] sec;
    logic [MS_W-1:0]    ms;
    logic               out_valid;
    logic               err;
    logic               busy;

    modport master (
        output clear, digit_in, digit_valid,
        input  digit_ready, hs, min, sec, ms, out_valid, err, busy
    );

    modport slave (
        input  clear, digit_in, digit_valid,
        output digit_ready, hs, min, sec, ms, out_valid, err, busy
    );

endinterface

// File: rtl/bcd_pair2bin.sv
// Converts a BCD tens/units pair to a 7-bit binary value (t*10 + u).
// Latency: combinational.
// Backpressure: none.
//
// Ports: tens, units (4-bit BCD digits, 0-9) in; bin (0-99) out.
module bcd_pair2bin
    import time_digit_pkg::*;
(
    input  logic [3:0]         tens,
    input  logic [3:0]         units,
    output logic [FIELD_W-1:0] bin
);

    logic [FIELD_W-1:0] t_w;
    logic [FIELD_W-1:0] u_w;

    assign t_w = FIELD_W'(tens);
    assign u_w = FIELD_W'(units);

    // t*10 as t*8 + t*2: shift-and-add, no multiplier.
    assign bin = (t_w << 3) + (t_w << 1) + u_w;

endmodule

// File: rtl/digit2time_parser.sv
// Parses an 11-symbol HH:MM:SS:DD digit stream into binary hs/min/sec/ms.
// Latency: out_valid in the 2nd cycle after the edge accepting the last symbol.
// Backpressure: digit_ready drops for the single COMMIT cycle of each frame.
//
// Ports: clk, reset_n (synchronous, active low); bus (digit2time_parser_if.slave):
//   clear/digit_in/digit_valid in, digit_ready, hs/min/sec/ms, out_valid/err
//   pulses and busy out.
// Optional: define RANGE_CHECK_EN to reject hs > HOUR_MAX, min > 59, sec > 59.
module digit2time_parser #(
    parameter logic [3:0] SEP_CODE = time_digit_pkg::SEP_CODE
`ifdef RANGE_CHECK_EN
    ,
    parameter int unsigned HOUR_MAX = 23
`endif
) (
    input  logic               clk,
    input  logic               reset_n,
    digit2time_parser_if.slave bus
);
    import time_digit_pkg::*;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0][3:0]    dig_q, dig_d;
    logic [FIELD_W-1:0] hs_q, hs_d;
    logic [FIELD_W-1:0] min_q, min_d;
    logic [FIELD_W-1:0] sec_q, sec_d;
    logic [MS_W-1:0]    ms_q, ms_d;
    logic               out_valid_q, out_valid_d;
    logic               err_q, err_d;

    logic               ready;
    logic               sym_bad;
    logic               range_ok;
    logic [FIELD_W-1:0] hs_bin, min_bin, sec_bin, dd_bin;
    logic [MS_W-1:0]    dd_wide, ms_bin;

    bcd_pair2bin u_hs  (.tens(dig_q[0]), .units(dig_q[1]), .bin(hs_bin));
    bcd_pair2bin u_min (.tens(dig_q[2]), .units(dig_q[3]), .bin(min_bin));
    bcd_pair2bin u_sec (.tens(dig_q[4]), .units(dig_q[5]), .bin(sec_bin));
    bcd_pair2bin u_dd  (.tens(dig_q[6]), .units(dig_q[7]), .bin(dd_bin));

    // D*100 as D*64 + D*32 + D*4.
    assign dd_wide = MS_W'(dd_bin);
    assign ms_bin  = (dd_wide << 6) + (dd_wide << 5) + (dd_wide << 2);

`ifdef RANGE_CHECK_EN
    assign range_ok = (hs_bin <= FIELD_W'(HOUR_MAX)) &&
                      (min_bin <= 7'd59) && (sec_bin <= 7'd59);
`else
    assign range_ok = 1'b1;
`endif

    assign ready = (state_q == COLLECT);

    // Separator slots must carry SEP_CODE; digit slots must carry 0-9.
    // The digit test also rejects SEP_CODE and the unused codes 11-15.
    always_comb begin
        sym_bad = 1'b0;
        if (is_sep_pos(idx_q)) begin
            sym_bad = (bus.digit_in != SEP_CODE);
        end else begin
            sym_bad = (bus.digit_in > 4'd9);
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dig_d       = dig_q;
        hs_d        = hs_q;
        min_d       = min_q;
        sec_d       = sec_q;
        ms_d        = ms_q;
        out_valid_d = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            COLLECT: begin
                // clear wins over a same-cycle accept: the symbol is dropped.
                if (bus.clear) begin
                    idx_d = '0;
                    dig_d = '0;
                end else if (bus.digit_valid) begin
                    if (sym_bad) begin
                        err_d = 1'b1;
                        idx_d = '0;
                        dig_d = '0;
                    end else begin
                        if (!is_sep_pos(idx_q)) begin
                            dig_d[digit_slot(idx_q)] = bus.digit_in;
                        end
                        // idx stays at LAST_IDX through COMMIT so busy stays high.
                        if (idx_q == LAST_IDX) begin
                            state_d = COMMIT;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end
                end
            end
            COMMIT: begin
                // clear is ignored here; the commit always completes.
                if (range_ok) begin
                    hs_d        = hs_bin;
                    min_d       = min_bin;
                    sec_d       = sec_bin;
                    ms_d        = ms_bin;
                    out_valid_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                idx_d   = '0;
                dig_d   = '0;
                state_d = COLLECT;
            end
            default: begin
                state_d = COLLECT;
                idx_d   = '0;
                dig_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= COLLECT;
            idx_q       <= '0;
            dig_q       <= '0;
            hs_q        <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            ms_q        <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dig_q       <= dig_d;
            hs_q        <= hs_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            ms_q        <= ms_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.digit_ready = ready;
    assign bus.hs          = hs_q;
    assign bus.min         = min_q;
    assign bus.sec         = sec_q;
    assign bus.ms          = ms_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.err         = err_q;
    assign bus.busy        = (idx_q != '0) || (state_q == COMMIT);

endmodule

// File: tb/tb_digit2time_parser.sv
// Self-checking bench for digit2time_parser with a stream-level reference model.
// Latency: n/a (testbench).
// Backpressure: driver holds each symbol until digit_ready is seen.
module tb_digit2time_parser;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    digit2time_parser_if bus ();

    digit2time_parser dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef logic [3:0] sym_q_t [$];
    typedef struct {
        int n_valid;
        int n_err;
        int n_both;
        int n_ready_low;
        int valid_cyc;
        int first_valid_cyc;
        int err_cyc;
        int last_acc;
        int timeouts;
    } obs_t;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: frames are judged from the accepted symbol stream.
    logic [3:0] m_frame [$];
    int m_hs, m_min, m_sec, m_ms, m_n_valid, m_n_err;

    function automatic void model_reset();
        m_frame.delete();
        m_hs = 0; m_min = 0; m_sec = 0; m_ms = 0;
    endfunction

    function automatic void model_clear();
        m_frame.delete();
    endfunction

    function automatic void model_accept(input logic [3:0] s);
        int  pos, h, mi, se, d;
        bit  bad, ok;
        pos = m_frame.size();
        bad = (pos == 2 || pos == 5 || pos == 8) ? (s != 4'd10) : (s > 4'd9);
        if (bad) begin
            m_n_err++;
            m_frame.delete();
            return;
        end
        m_frame.push_back(s);
        if (m_frame.size() == 11) begin
            h  = m_frame[0] * 10 + m_frame[1];
            mi = m_frame[3] * 10 + m_frame[4];
            se = m_frame[6] * 10 + m_frame[7];
            d  = m_frame[9] * 10 + m_frame[10];
            ok = 1'b1;
`ifdef RANGE_CHECK_EN
            ok = (h <= 23) && (mi <= 59) && (se <= 59);
`endif
            if (ok) begin
                m_hs = h; m_min = mi; m_sec = se; m_ms = d * 100;
                m_n_valid++;
            end else begin
                m_n_err++;
            end
            m_frame.delete();
        end
    endfunction

    function automatic logic [35:0] exp_vals();
        return {7'(m_hs), 7'(m_min), 7'(m_sec), 15'(m_ms)};
    endfunction

    function automatic logic [35:0] act_vals();
        return {bus.hs, bus.min, bus.sec, bus.ms};
    endfunction

    // First n nibbles of v, most significant first (A = separator).
    function automatic void mk(input logic [43:0] v, input int n, output sym_q_t q);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(v[43 - 4*i -: 4]);
    endfunction

    // Random frame that is legal in both builds.
    function automatic void mk_legal(output sym_q_t q);
        q.delete();
        q.push_back(4'($urandom_range(0, 1))); q.push_back(4'($urandom_range(0, 9)));
        q.push_back(4'd10);
        q.push_back(4'($urandom_range(0, 5))); q.push_back(4'($urandom_range(0, 9)));
        q.push_back(4'd10);
        q.push_back(4'($urandom_range(0, 5))); q.push_back(4'($urandom_range(0, 9)));
        q.push_back(4'd10);
        q.push_back(4'($urandom_range(0, 9))); q.push_back(4'($urandom_range(0, 9)));
    endfunction

    task automatic tick(inout obs_t o);
        @(posedge clk);
        #1;
        cyc++;
        if (bus.out_valid === 1'b1) begin
            if (o.n_valid == 0) o.first_valid_cyc = cyc;
            o.n_valid++;
            o.valid_cyc = cyc;
        end
        if (bus.err === 1'b1) begin
            o.n_err++;
            o.err_cyc = cyc;
        end
        if (bus.out_valid === 1'b1 && bus.err === 1'b1) o.n_both++;
        if (bus.digit_ready !== 1'b1) o.n_ready_low++;
    endtask

    // Feeds syms with optional random idle gaps; clear rides with symbol clear_at.
    task automatic drive(input sym_q_t syms, input int gap_pct, input int clear_at,
                         output obs_t o);
        o = '{default: 0};
        for (int i = 0; i < syms.size(); i++) begin
            bit acc;
            int waited;
            if (int'($urandom_range(0, 99)) < gap_pct) begin
                bus.digit_valid = 1'b0;
                bus.clear       = 1'b0;
                repeat ($urandom_range(1, 3)) tick(o);
            end
            bus.digit_in    = syms[i];
            bus.digit_valid = 1'b1;
            bus.clear       = (i == clear_at);
            acc    = 1'b0;
            waited = 0;
            while (!acc && waited < 20) begin
                acc = (bus.digit_ready === 1'b1);
                tick(o);
                waited++;
            end
            if (!acc) o.timeouts++;
            o.last_acc = cyc;
            if (i == clear_at) model_clear();
            else model_accept(syms[i]);
        end
        bus.digit_valid = 1'b0;
        bus.clear       = 1'b0;
        repeat (4) tick(o);
    endtask

    task automatic test_reset();
        obs_t o;
        o = '{default: 0};
        reset_n = 1'b0; bus.clear = 1'b0; bus.digit_valid = 1'b0; bus.digit_in = 4'd0;
        tick(o); tick(o);
        n_checks++;
        if (act_vals() !== 36'd0)
            begin n_fail++; $display("FAIL reset_values: got %h, expected 0", act_vals()); end
        n_checks++;
        if ({bus.out_valid, bus.err, bus.busy, bus.digit_ready} !== 4'b0001)
            begin n_fail++; $display("FAIL reset_flags: got valid/err/busy/ready=%b, expected 0001",
                {bus.out_valid, bus.err, bus.busy, bus.digit_ready}); end
        reset_n = 1'b1;
        tick(o);
        model_reset();
    endtask

    task automatic test_basic();
        obs_t o; sym_q_t q; int v0, e0;
        v0 = m_n_valid; e0 = m_n_err;
        mk(44'h12A34A56A78, 11, q);
        drive(q, 0, -1, o);
        n_checks++;
        if (act_vals() !== exp_vals() || m_ms !== 7800)
            begin n_fail++; $display("FAIL basic_values: got %0d/%0d/%0d/%0d, expected %0d/%0d/%0d/%0d",
                bus.hs, bus.min, bus.sec, bus.ms, m_hs, m_min, m_sec, m_ms); end
        n_checks++;
        if (o.n_valid !== m_n_valid - v0 || o.n_err !== m_n_err - e0 || o.n_both !== 0 || o.timeouts !== 0)
            begin n_fail++; $display("FAIL basic_counts: got valid=%0d err=%0d both=%0d timeouts=%0d, expected %0d/%0d/0/0",
                o.n_valid, o.n_err, o.n_both, o.timeouts, m_n_valid - v0, m_n_err - e0); end
        n_checks++;
        if (o.valid_cyc - o.last_acc + 1 !== 2)
            begin n_fail++; $display("FAIL basic_latency: got out_valid in cycle %0d after accept, expected 2",
                o.valid_cyc - o.last_acc + 1); end
        n_checks++;
        if (o.n_ready_low !== 1)
            begin n_fail++; $display("FAIL basic_ready_low: got %0d cycles, expected 1", o.n_ready_low); end
    endtask

    task automatic test_gaps();
        obs_t o; sym_q_t q; int v0, e0;
        v0 = m_n_valid; e0 = m_n_err;
        mk(44'h00A59A59A99, 11, q);
        drive(q, 40, -1, o);
        n_checks++;
        if (act_vals() !== exp_vals() || m_ms !== 9900)
            begin n_fail++; $display("FAIL gaps_values: got %0d/%0d/%0d/%0d, expected %0d/%0d/%0d/%0d",
                bus.hs, bus.min, bus.sec, bus.ms, m_hs, m_min, m_sec, m_ms); end
        n_checks++;
        if (o.n_valid !== m_n_valid - v0 || o.n_err !== m_n_err - e0 || o.n_both !== 0 || o.timeouts !== 0)
            begin n_fail++; $display("FAIL gaps_counts: got valid=%0d err=%0d both=%0d timeouts=%0d, expected %0d/%0d/0/0",
                o.n_valid, o.n_err, o.n_both, o.timeouts, m_n_valid - v0, m_n_err - e0); end
        n_checks++;
        if (o.valid_cyc - o.last_acc + 1 !== 2)
            begin n_fail++; $display("FAIL gaps_latency: got cycle %0d, expected 2", o.valid_cyc - o.last_acc + 1); end
    endtask

    task automatic test_framing_err();
        obs_t o; sym_q_t q;
        mk(44'h12300000000, 3, q);
        drive(q, 0, -1, o);
        n_checks++;
        if (o.n_err !== 1 || o.n_valid !== 0 || o.timeouts !== 0)
            begin n_fail++; $display("FAIL framing_counts: got err=%0d valid=%0d timeouts=%0d, expected 1/0/0",
                o.n_err, o.n_valid, o.timeouts); end
        n_checks++;
        if (o.err_cyc - o.last_acc + 1 !== 1)
            begin n_fail++; $display("FAIL framing_err_timing: got cycle %0d, expected 1", o.err_cyc - o.last_acc + 1); end
        n_checks++;
        if (act_vals() !== exp_vals() || bus.busy !== 1'b0)
            begin n_fail++; $display("FAIL framing_hold: got %0d/%0d/%0d/%0d busy=%b, expected %0d/%0d/%0d/%0d busy=0",
                bus.hs, bus.min, bus.sec, bus.ms, bus.busy, m_hs, m_min, m_sec, m_ms); end
        mk(44'h23A45A01A12, 11, q);
        drive(q, 0, -1, o);
        n_checks++;
        if (act_vals() !== exp_vals() || o.n_valid !== 1 || o.n_err !== 0)
            begin n_fail++; $display("FAIL framing_recover: got %0d/%0d/%0d/%0d valid=%0d err=%0d, expected %0d/%0d/%0d/%0d 1/0",
                bus.hs, bus.min, bus.sec, bus.ms, o.n_valid, o.n_err, m_hs, m_min, m_sec, m_ms); end
    endtask

    task automatic test_range();
        obs_t o; sym_q_t q; int v0, e0;
        v0 = m_n_valid; e0 = m_n_err;
        mk(44'h24A00A00A00, 11, q);
        drive(q, 0, -1, o);
        n_checks++;
        if (act_vals() !== exp_vals())
            begin n_fail++; $display("FAIL range_values: got %0d/%0d/%0d/%0d, expected %0d/%0d/%0d/%0d",
                bus.hs, bus.min, bus.sec, bus.ms, m_hs, m_min, m_sec, m_ms); end
        n_checks++;
        if (o.n_valid !== m_n_valid - v0 || o.n_err !== m_n_err - e0 || o.n_both !== 0)
            begin n_fail++; $display("FAIL range_counts: got valid=%0d err=%0d both=%0d, expected %0d/%0d/0",
                o.n_valid, o.n_err, o.n_both, m_n_valid - v0, m_n_err - e0); end
    endtask

    task automatic test_clear();
        obs_t o; sym_q_t q;
        mk(44'h01A02A00000, 6, q);
        drive(q, 0, -1, o);
        n_checks++;
        if (bus.busy !== 1'b1)
            begin n_fail++; $display("FAIL clear_busy_mid: got busy=%b, expected 1", bus.busy); end
        mk(44'h60000000000, 1, q);
        drive(q, 0, 0, o);
        n_checks++;
        if (o.n_err !== 0 || o.n_valid !== 0 || bus.busy !== 1'b0)
            begin n_fail++; $display("FAIL clear_drop: got err=%0d valid=%0d busy=%b, expected 0/0/0",
                o.n_err, o.n_valid, bus.busy); end
        mk(44'h01A02A03A04, 11, q);
        drive(q, 0, -1, o);
        n_checks++;
        if (act_vals() !== {7'd1, 7'd2, 7'd3, 15'd400} || act_vals() !== exp_vals() || o.n_valid !== 1)
            begin n_fail++; $display("FAIL clear_restart: got %0d/%0d/%0d/%0d valid=%0d, expected 1/2/3/400 valid=1",
                bus.hs, bus.min, bus.sec, bus.ms, o.n_valid); end
    endtask

    task automatic test_back_to_back();
        obs_t o; sym_q_t q, q2;
        mk_legal(q);
        mk_legal(q2);
        foreach (q2[i]) q.push_back(q2[i]);
        drive(q, 0, -1, o);
        n_checks++;
        if (act_vals() !== exp_vals() || o.n_valid !== 2 || o.n_err !== 0)
            begin n_fail++; $display("FAIL b2b_values: got %0d/%0d/%0d/%0d valid=%0d err=%0d, expected %0d/%0d/%0d/%0d 2/0",
                bus.hs, bus.min, bus.sec, bus.ms, o.n_valid, o.n_err, m_hs, m_min, m_sec, m_ms); end
        n_checks++;
        if (o.valid_cyc - o.first_valid_cyc !== 12 || o.n_ready_low !== 2)
            begin n_fail++; $display("FAIL b2b_throughput: got spacing=%0d ready_low=%0d, expected 12/2",
                o.valid_cyc - o.first_valid_cyc, o.n_ready_low); end
    endtask

    task automatic test_reset_mid();
        obs_t o, r; sym_q_t q;
        mk(44'h01A02A00000, 7, q);
        drive(q, 0, -1, o);
        r = '{default: 0};
        bus.digit_in = 4'd3; bus.digit_valid = 1'b1; reset_n = 1'b0;
        tick(r); tick(r);
        n_checks++;
        if (act_vals() !== 36'd0 || {bus.out_valid, bus.err, bus.busy, bus.digit_ready} !== 4'b0001)
            begin n_fail++; $display("FAIL reset_mid_state: got %h flags=%b, expected 0 flags=0001", act_vals(),
                {bus.out_valid, bus.err, bus.busy, bus.digit_ready}); end
        reset_n = 1'b1; bus.digit_valid = 1'b0;
        tick(r);
        model_reset();
        mk_legal(q);
        drive(q, 20, -1, o);
        n_checks++;
        if (act_vals() !== exp_vals() || o.n_valid !== 1 || o.n_err !== 0 || r.n_valid !== 0 || r.n_err !== 0)
            begin n_fail++; $display("FAIL reset_mid_parse: got %0d/%0d/%0d/%0d valid=%0d err=%0d, expected %0d/%0d/%0d/%0d 1/0",
                bus.hs, bus.min, bus.sec, bus.ms, o.n_valid + r.n_valid, o.n_err + r.n_err, m_hs, m_min, m_sec, m_ms); end
    endtask

    task automatic test_random();
        obs_t o; sym_q_t q, f; int v0, e0;
        v0 = m_n_valid; e0 = m_n_err;
        q.delete();
        for (int k = 0; k < 10; k++) begin
            mk_legal(f);
            if ($urandom_range(0, 99) < 40) f[$urandom_range(0, 10)] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 20) f[0] = 4'($urandom_range(2, 9));
            foreach (f[i]) q.push_back(f[i]);
        end
        drive(q, 30, -1, o);
        n_checks++;
        if (act_vals() !== exp_vals())
            begin n_fail++; $display("FAIL random_values: got %0d/%0d/%0d/%0d, expected %0d/%0d/%0d/%0d",
                bus.hs, bus.min, bus.sec, bus.ms, m_hs, m_min, m_sec, m_ms); end
        n_checks++;
        if (o.n_valid !== m_n_valid - v0 || o.n_err !== m_n_err - e0 || o.n_both !== 0 || o.timeouts !== 0)
            begin n_fail++; $display("FAIL random_counts: got valid=%0d err=%0d both=%0d timeouts=%0d, expected %0d/%0d/0/0",
                o.n_valid, o.n_err, o.n_both, o.timeouts, m_n_valid - v0, m_n_err - e0); end
    endtask

    initial begin
        m_n_valid = 0; m_n_err = 0;
        model_reset();
        test_reset();
        test_basic();
        test_gaps();
        test_framing_err();
        test_range();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/digit2time_parser.md
Name: digit2time_parser

Overview:
- Reverse of the time-to-digit formatter: accepts a serial stream of 4-bit digit codes (HH:MM:SS:DD, separator code 10) over a valid/ready handshake.
- Assembles binary hs/min/sec/ms fields from the stream and validates its framing.
- Sits between the keypad/UART digit source and the stopwatch/clock preset logic.
- Publishes one registered time value per complete 11-symbol frame.

Parameters:
- SEP_CODE, 10, digit code treated as field separator.
- HOUR_MAX, 23, maximum legal hour; used only when RANGE_CHECK_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- clear  in  1  synchronous abort of the current frame; returns to symbol index 0.
- digit_in  in  4  digit code: 0-9 digit, SEP_CODE separator.
- digit_valid  in  1  digit_in valid.
- digit_ready  out  1  block can accept a symbol this cycle.
- hs  out  7  parsed hours.
- min  out  7  parsed minutes.
- sec  out  7  parsed seconds.
- ms  out  15  parsed milliseconds, always a multiple of 100.
- out_valid  out  1  one-cycle pulse: new hs/min/sec/ms are valid.
- err  out  1  one-cycle pulse: frame rejected.
- busy  out  1  high while symbol index is nonzero or in COMMIT.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - idx=0, state COLLECT.
  - hs/min/sec/ms=0; out_valid=0, err=0, busy=0, digit_ready=1.
  - Reset mid-frame discards all partial data.
- Transfer: a symbol is accepted on a clk edge with digit_valid && digit_ready. digit_in must be stable while valid && !ready.
- Frame layout, indexed 0..10 in acceptance order:
  - 0 H tens, 1 H units, 2 SEP.
  - 3 M tens, 4 M units, 5 SEP.
  - 6 S tens, 7 S units, 8 SEP.
  - 9 D tens, 10 D units, where D = ms/100.
- State COLLECT:
  - digit_ready=1.
  - Each accepted digit is stored into its tens/units staging register; idx increments.
  - Framing error: SEP at a digit position, non-SEP at positions 2/5/8, or any code 11-15. On error: err pulses the next cycle, idx returns to 0, staging is cleared, outputs keep their previous values.
  - Acceptance at idx=10 without error moves to COMMIT.
- State COMMIT (exactly one cycle):
  - digit_ready=0.
  - Each field = tens*10+units (7 bits, max 99).
  - ms = D*100, computed as (D<<6)+(D<<5)+(D<<2), 15 bits, max 9900.
  - Range check (if enabled) is applied here.
  - On pass: outputs are registered and out_valid pulses the following cycle. On fail: err pulses, outputs are unchanged.
  - Then idx=0, state COLLECT.
- Latency: out_valid asserts 2 cycles after the edge that accepts symbol 10. Throughput: 1 frame per 12 cycles minimum.
- clear:
  - In COLLECT: takes priority over a simultaneous accept; the symbol is dropped, idx=0, no err.
  - In COMMIT: ignored; the commit completes.
- out_valid and err are never high in the same cycle.
- hs/min/sec/ms hold their value between commits.

Optional Feature:
- Macro RANGE_CHECK_EN.
- Defined: COMMIT rejects (err pulse) when hs>HOUR_MAX, min>59 or sec>59. Tens digits are not checked individually, only the composed values.
- Undefined: any 00-99 value is accepted for every field; HOUR_MAX is unused.

Decomposition:
- Shared package time_digit_pkg:
  - SEP_CODE (10), NUM_SYMBOLS (11).
  - Separator position constants (2, 5, 8).
  - Field width constants (7, 15).
  - State enum {COLLECT, COMMIT}.
  - The same package is used by the formatter.
- One combinational sub-module, bcd_pair2bin: tens, units in; 7-bit binary out via (t<<3)+(t<<1)+u. Instanced four times.

Test Plan:
- Stream 1,2,10,3,4,10,5,6,10,7,8 with valid held high -> out_valid pulse; hs=12, min=34, sec=56, ms=7800; digit_ready=0 for exactly one cycle.
- Stream 0,0,10,5,9,10,5,9,10,9,9 with random valid gaps -> hs=0, min=59, sec=59, ms=9900.
- Symbol 3 at index 2 (1,2,3,...) -> err pulse only, idx back to 0; a following valid frame parses correctly and outputs retain prior values meanwhile.
- RANGE_CHECK_EN defined, frame 2,4,10,0,0,10,0,0,10,0,0 -> err, outputs unchanged. Same frame with macro undefined -> hs=24.
- clear asserted together with symbol 6 accepted -> no err, frame restarts; next full frame 0,1,10,0,2,10,0,3,10,0,4 -> 1/2/3/400.
- reset_n low during symbol 7, then a full frame -> all outputs 0 during reset, correct parse afterwards, no spurious out_valid or err.
